lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: none; all widths fixed at 32-bit RV32I.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  LSU can accept; a request is accepted when req_valid && req_ready at posedge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-justified (rs2).
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  request rejected, with no memory access; valid with resp_valid.
REQ-013 mem_read, mem_write  output  1 each  memory strobes; never both high.
REQ-014 mem_addr  output  32  word-aligned byte address, {addr[31:2],2'b00}.
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_rdata  input  32  combinational read data, valid in the same cycle as mem_read.

Function
REQ-017 FSM states are IDLE, RD, RMW_RD, WR and RESP; req_ready=1 only in IDLE.
REQ-018 On acceptance in IDLE, the LSU latches we/funct3/addr/wdata and transitions as follows:
- load -> RD.
- SW -> WR.
- SB/SH -> RMW_RD.
- error -> RESP.
REQ-019 RD asserts mem_read for one cycle, captures the extracted/extended lane into rdata and goes to RESP.
REQ-020 Load extraction uses byte lane addr[1:0] and half lane addr[1]; B/H sign-extend, BU/HU zero-extend.
REQ-021 RMW_RD asserts mem_read for one cycle, merges store data into the addressed lane(s) of mem_rdata into a word buffer and goes to WR.
REQ-022 WR asserts mem_write for exactly one cycle with mem_wdata = buffer (SW: req_wdata) and goes to RESP.
REQ-023 RESP asserts resp_valid for one cycle and goes to IDLE; the request is accepted again no earlier than the next cycle.
REQ-024 Latency from the acceptance edge to the resp_valid cycle is: load 2 cycles, SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
REQ-025 Illegal funct3 (011, 110, 111; store with 100/101) -> resp_err=1 with no mem strobe.
REQ-026 mem_* outputs are decoded from the state and latched registers only; req_* changes after acceptance have no effect.
REQ-027 resp_rdata holds its value until the next response; stores and errors return 0.

Reset
REQ-028 While rst_n=0: state=IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, buffers=0.
REQ-029 Reset asserted in any state aborts the operation immediately; mem_write falls asynchronously and no partial write is issued after release.
REQ-030 req_ready=1 from the first cycle after rst_n deasserts.

Configuration
REQ-031 Macro LSU_MISALIGN_TRAP_EN: when defined, H/HU/SH with addr[0]=1 and W/SW with addr[1:0]!=0 -> resp_err=1 with no memory access.
REQ-032 When LSU_MISALIGN_TRAP_EN is undefined: H forces addr[0]=0, W forces addr[1:0]=0, and resp_err is driven only by illegal funct3.

Structure
REQ-033 Package lsu_pkg holds the funct3 width constants and the FSM state enumeration.
REQ-034 Sub-module lsu_align holds the combinational lane extract/extend and lane merge logic, instantiated once in lsu.

Verification
REQ-035 LW: memory word 5 = 0xDEADBEEF; load funct3=010, addr=0x14 -> one mem_read cycle at 0x14, then resp_valid with rdata=0xDEADBEEF, err=0.
REQ-036 LB/LBU: word at 0x20 = 0x80FF7F01; LB addr=0x22 -> 0xFFFFFFFF; LBU addr=0x23 -> 0x00000080; LH addr=0x22 -> 0xFFFF80FF.
REQ-037 SB: word at 0x40 = 0x11223344; SB addr=0x41, wdata=0xAA -> mem_read, then mem_write with 0x1122AA44; resp 3 cycles after acceptance.
REQ-038 Misaligned SW addr=0x42, wdata=0x5:
- with LSU_MISALIGN_TRAP_EN: resp_err=1 with no mem strobe.
- without it: write of 0x5 to 0x40.
REQ-039 Reset in WR: assert rst_n=0 during an SH -> mem_write drops immediately; the memory word is unchanged.
REQ-040 Back-to-back: req_valid held high with two LWs -> req_ready low during RD/RESP; the second is accepted on the first IDLE edge; funct3=011 -> resp_err=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared definitions for the RV32I load/store unit.
// Holds the funct3 access-width codes and the LSU FSM state encoding.
// Optional build macro LSU_MISALIGN_TRAP_EN is interpreted in lsu.sv.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RMW_RD,
      WR,
      RESP
   } state_t;

endpackage

// File: rtl/lsu_if.sv
// lsu_if -- core-side request/response handshake of the LSU.
// Signals:
//   req_valid/req_ready  request handshake (accept on valid && ready at posedge)
//   req_we               1 = store, 0 = load
//   req_funct3           RV32I width code
//   req_addr, req_wdata  byte address, right-justified store data
//   resp_valid           one-cycle completion pulse
//   resp_rdata, resp_err extended load data / rejection flag
// Modports: master = core side, slave = LSU side.
interface lsu_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );

endinterface

// File: rtl/lsu_align.sv
// lsu_align -- combinational lane logic for the LSU.
// Ports:
//   funct3     access width code
//   lane       byte offset within the word (addr[1:0])
//   word       memory word read back
//   store      right-justified store data
//   load_data  extracted lane, sign/zero-extended per funct3
//   merge_word word with the store data merged into the addressed lane(s)
// Halfword accesses select the lane by lane[1] alone, so an odd halfword
// address behaves as the aligned one.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] store,
   output logic [31:0] load_data,
   output logic [31:0] merge_word
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      shifted = word >> {lane, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = lane[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
         F3_BU:   load_data = {24'h0, byte_v};
         F3_H:    load_data = {{16{half_v[15]}}, half_v};
         F3_HU:   load_data = {16'h0, half_v};
         default: load_data = word;
      endcase
   end

   always_comb begin
      merge_word = word;
      case (funct3)
         F3_B: merge_word[{lane, 3'b000} +: 8] = store[7:0];
         F3_H: begin
            if (lane[1]) merge_word[31:16] = store[15:0];
            else         merge_word[15:0]  = store[15:0];
         end
         default: merge_word = store;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// lsu -- RV32I load/store unit with read-modify-write for sub-word stores.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   bus (lsu_if.slave)   core request/response handshake
//   mem_read, mem_write  memory strobes (never both high)
//   mem_addr             word-aligned address of the latched request
//   mem_wdata            full word to write
//   mem_rdata            combinational read data, same cycle as mem_read
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned H/HU/SH and
// W/SW accesses are rejected with resp_err; otherwise the low address bits
// are ignored for those widths.
module lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   lsu_if.slave        bus,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   state_t      state_q, state_d;
   logic        we_q, err_q, req_bad, accept;
   logic [2:0]  f3_q;
   logic [31:0] addr_q, wdata_q, buf_q, rdata_q;
   logic [31:0] load_data, merge_word;

   lsu_align u_align (
      .funct3     (f3_q),
      .lane       (addr_q[1:0]),
      .word       (mem_rdata),
      .store      (wdata_q),
      .load_data  (load_data),
      .merge_word (merge_word)
   );

   always_comb begin
      req_bad = 1'b0;
      case (bus.req_funct3)
         F3_B, F3_H, F3_W: req_bad = 1'b0;
         F3_BU, F3_HU:     req_bad = bus.req_we;
         default:          req_bad = 1'b1;
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      if ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0])
         req_bad = 1'b1;
      if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00)
         req_bad = 1'b1;
`endif
   end

   // ready is gated by rst_n so it stays low while reset is held
   assign bus.req_ready = (state_q == IDLE) && rst_n;
   assign accept        = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_bad)                      state_d = RESP;
               else if (!bus.req_we)             state_d = RD;
               else if (bus.req_funct3 == F3_W)  state_d = WR;
               else                              state_d = RMW_RD;
            end
         end
         RD:      state_d = RESP;
         RMW_RD:  state_d = WR;
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && accept) begin
            we_q    <= bus.req_we;
            err_q   <= req_bad;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (state_q == RMW_RD)
            buf_q <= merge_word;
         // rdata changes only on entry to RESP: loaded lane, or 0 for stores/errors
         if (state_q == RD)
            rdata_q <= load_data;
         else if (state_q == WR || (state_q == IDLE && accept && req_bad))
            rdata_q <= '0;
      end
   end

   assign mem_read       = (state_q == RD) || (state_q == RMW_RD);
   assign mem_write      = (state_q == WR);
   assign mem_addr       = {addr_q[31:2], 2'b00};
   assign mem_wdata      = (we_q && f3_q == F3_W) ? wdata_q : buf_q;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu -- directed, table-driven bench for lsu with a small word memory.
// Honors LSU_MISALIGN_TRAP_EN for the misaligned-access expectations.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   lsu_if bus ();

   lsu dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:63];
   logic        pl_en = 1'b0;
   logic [5:0]  pl_idx = '0;
   logic [31:0] pl_val = '0;
   logic        both_seen = 1'b0;

   assign mem_rdata = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (pl_en)          mem[pl_idx] <= pl_val;
      else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
      if (mem_read && mem_write) both_seen <= 1'b1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input logic [5:0] idx, input logic [31:0] val);
      @(negedge clk);
      pl_idx = idx;
      pl_val = val;
      pl_en  = 1'b1;
      @(negedge clk);
      pl_en  = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
      logic [31:0] after;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] init,
                               logic [31:0] rdata, logic err, int lat,
                               int reads, int writes, logic [31:0] after);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.init = init;
      v.rdata = rdata; v.err = err; v.lat = lat; v.reads = reads;
      v.writes = writes; v.after = after;
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int          lat, reads, writes;
      logic        addr_bad, got, er;
      logic [31:0] rd;
      string       tag;
      tag = $sformatf("v%0d", idx);
      preload(v.addr[7:2], v.init);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = v.we;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      for (int k = 0; k < 8 && !bus.req_ready; k++) @(negedge clk);
      chk({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
      @(posedge clk);
      #1;
      // scramble request inputs; the accepted operation must not notice
      bus.req_valid  = 1'b0;
      bus.req_we     = ~v.we;
      bus.req_funct3 = 3'b111;
      bus.req_addr   = 32'hFFFF_FFFF;
      bus.req_wdata  = 32'hFFFF_FFFF;
      lat = 1; reads = 0; writes = 0; addr_bad = 1'b0; got = 1'b0;
      er = 1'b0; rd = '0;
      for (int c = 0; c < 10; c++) begin
         if (mem_read)  reads++;
         if (mem_write) writes++;
         if ((mem_read || mem_write) && mem_addr !== {v.addr[31:2], 2'b00})
            addr_bad = 1'b1;
         if (bus.resp_valid) begin
            got = 1'b1;
            rd  = bus.resp_rdata;
            er  = bus.resp_err;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_resp_seen"}, {31'h0, got}, 32'h1);
      chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_rdata"}, rd, v.rdata);
      chk({tag, "_err"}, {31'h0, er}, {31'h0, v.err});
      chk({tag, "_reads"}, reads, v.reads);
      chk({tag, "_writes"}, writes, v.writes);
      chk({tag, "_mem_addr"}, {31'h0, addr_bad}, 32'h0);
      chk({tag, "_mem_word"}, mem[v.addr[7:2]], v.after);
      @(posedge clk);
      #1;
      chk({tag, "_pulse_end"}, {31'h0, bus.resp_valid}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic wr_seen;

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;

      // reset state
      #2;
      chk("rst_ready", {31'h0, bus.req_ready}, 32'h0);
      chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ready", {31'h0, bus.req_ready}, 32'h1);

      vt.push_back(mk(0, 3'b010, 32'h14, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF));
      vt.push_back(mk(0, 3'b000, 32'h22, 0, 32'h80FF7F01, 32'hFFFFFFFF, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b100, 32'h23, 0, 32'h80FF7F01, 32'h00000080, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b001, 32'h22, 0, 32'h80FF7F01, 32'hFFFF80FF, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b101, 32'h20, 0, 32'h80FF7F01, 32'h00007F01, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b000, 32'h20, 0, 32'h80FF7F01, 32'h00000001, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b100, 32'h21, 0, 32'h80FF7F01, 32'h0000007F, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(1, 3'b000, 32'h41, 32'hAA, 32'h11223344, 0, 0, 3, 1, 1, 32'h1122AA44));
      vt.push_back(mk(1, 3'b000, 32'h43, 32'h123456EE, 32'h11223344, 0, 0, 3, 1, 1, 32'hEE223344));
      vt.push_back(mk(1, 3'b001, 32'h42, 32'h1234BEEF, 32'h11223344, 0, 0, 3, 1, 1, 32'hBEEF3344));
      vt.push_back(mk(1, 3'b010, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0, 2, 0, 1, 32'hCAFEF00D));
      vt.push_back(mk(0, 3'b011, 32'h14, 0, 32'hDEADBEEF, 0, 1, 1, 0, 0, 32'hDEADBEEF));
      vt.push_back(mk(1, 3'b100, 32'h44, 32'h12, 32'h0BADF00D, 0, 1, 1, 0, 0, 32'h0BADF00D));
      vt.push_back(mk(0, 3'b110, 32'h48, 0, 32'h01020304, 0, 1, 1, 0, 0, 32'h01020304));
      vt.push_back(mk(1, 3'b111, 32'h4C, 32'h77, 32'h0A0B0C0D, 0, 1, 1, 0, 0, 32'h0A0B0C0D));
`ifdef LSU_MISALIGN_TRAP_EN
      vt.push_back(mk(1, 3'b010, 32'h42, 32'h5, 32'h99999999, 0, 1, 1, 0, 0, 32'h99999999));
      vt.push_back(mk(0, 3'b001, 32'h23, 0, 32'h80FF7F01, 0, 1, 1, 0, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b010, 32'h17, 0, 32'hDEADBEEF, 0, 1, 1, 0, 0, 32'hDEADBEEF));
      vt.push_back(mk(0, 3'b101, 32'h21, 0, 32'h80FF7F01, 0, 1, 1, 0, 0, 32'h80FF7F01));
`else
      vt.push_back(mk(1, 3'b010, 32'h42, 32'h5, 32'h99999999, 0, 0, 2, 0, 1, 32'h00000005));
      vt.push_back(mk(0, 3'b001, 32'h23, 0, 32'h80FF7F01, 32'hFFFF80FF, 0, 2, 1, 0, 32'h80FF7F01));
      vt.push_back(mk(0, 3'b010, 32'h17, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2, 1, 0, 32'hDEADBEEF));
      vt.push_back(mk(0, 3'b101, 32'h21, 0, 32'h80FF7F01, 32'h00007F01, 0, 2, 1, 0, 32'h80FF7F01));
`endif

      for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

      // back-to-back loads with req_valid held high
      preload(6'd5, 32'hDEADBEEF);
      preload(6'd9, 32'h01234567);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b010;
      bus.req_addr   = 32'h14;
      chk("b2b_ready_idle", {31'h0, bus.req_ready}, 32'h1);
      @(posedge clk);
      #1;
      bus.req_addr = 32'h24;
      chk("b2b_ready_rd", {31'h0, bus.req_ready}, 32'h0);
      chk("b2b_read1", {31'h0, mem_read}, 32'h1);
      chk("b2b_addr1", mem_addr, 32'h14);
      @(posedge clk);
      #1;
      chk("b2b_resp1", {31'h0, bus.resp_valid}, 32'h1);
      chk("b2b_ready_resp", {31'h0, bus.req_ready}, 32'h0);
      chk("b2b_rdata1", bus.resp_rdata, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      chk("b2b_ready_idle2", {31'h0, bus.req_ready}, 32'h1);
      chk("b2b_no_resp", {31'h0, bus.resp_valid}, 32'h0);
      chk("b2b_rdata_hold", bus.resp_rdata, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      chk("b2b_accept2", {31'h0, bus.req_ready}, 32'h0);
      chk("b2b_read2", {31'h0, mem_read}, 32'h1);
      chk("b2b_addr2", mem_addr, 32'h24);
      @(posedge clk);
      #1;
      chk("b2b_resp2", {31'h0, bus.resp_valid}, 32'h1);
      chk("b2b_rdata2", bus.resp_rdata, 32'h01234567);

      // reset asserted while an SH sits in WR
      preload(6'd20, 32'h55667788);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_funct3 = 3'b001;
      bus.req_addr   = 32'h52;
      bus.req_wdata  = 32'h0000AAAA;
      for (int k = 0; k < 8 && !bus.req_ready; k++) @(negedge clk);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      for (int k = 0; k < 5 && !mem_write; k++) begin
         @(posedge clk);
         #1;
      end
      chk("rwr_reached", {31'h0, mem_write}, 32'h1);
      rst_n = 1'b0;
      #1;
      chk("rwr_write_drop", {31'h0, mem_write}, 32'h0);
      chk("rwr_ready_low", {31'h0, bus.req_ready}, 32'h0);
      chk("rwr_resp_low", {31'h0, bus.resp_valid}, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rwr_ready_rel", {31'h0, bus.req_ready}, 32'h1);
      wr_seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (mem_write) wr_seen = 1'b1;
      end
      chk("rwr_no_write", {31'h0, wr_seen}, 32'h0);
      chk("rwr_word_kept", mem[20], 32'h55667788);

      chk("strobe_exclusive", {31'h0, both_seen}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
